// File: rtl/async_fifo_read_ctrl.sv
// Read-side controller for a dual-clock FIFO: syncs the Gray write pointer,
// fetches from registered-read memory and streams words out via valid/ready.
//
// Ports:
//   rd_clk, rd_rst      read clock, synchronous active-high reset
//   wr_ptr_gray         Gray write pointer from the write domain (async)
//   rd_ptr_gray         registered Gray read pointer to the write domain
//   read_addr/read_data memory read port (one-cycle registered latency)
//   out_data/out_valid/out_ready  output stream
//   empty, rd_level     synced occupancy view (unfetched words)
module async_fifo_read_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]         sync_q [SYNC_STAGES];
    logic [PW-1:0]         wq_gray;
    logic [PW-1:0]         wq_bin;

    logic [PW-1:0]         rd_bin_q, rd_bin_d;
    logic [PW-1:0]         rd_gray_q, rd_gray_d;
    logic                  inflight_q;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

    logic                  pop;
    logic [1:0]            occ;
    logic [1:0]            occ_after_pop;
    logic                  fetch;

    // Synchronizer on the incoming Gray write pointer
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_gray = sync_q[SYNC_STAGES-1];
    assign wq_bin  = gray2bin(wq_gray);

    assign empty     = (wq_gray == rd_gray_q);
    assign rd_level  = wq_bin - rd_bin_q;
    assign read_addr = rd_bin_q[ADDR_WIDTH-1:0];

    // Occupancy counts the word still in the memory pipeline so that the
    // two-entry buffer can never overflow under backpressure.
    assign pop           = out_valid_q & out_ready;
    assign occ           = {1'b0, out_valid_q} + {1'b0, skid_valid_q}
                         + {1'b0, inflight_q};
    assign occ_after_pop = occ - {1'b0, pop};
    assign fetch         = !empty && (occ_after_pop < 2'd2);

    assign rd_bin_d  = rd_bin_q + {{(PW-1){1'b0}}, fetch};
    assign rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);

    // Output register plus skid: pop/move first, then place the arrival
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (pop) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (inflight_q) begin
            if (!out_valid_d) begin
                out_valid_d = 1'b1;
                out_data_d  = read_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = read_data;
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_bin_q     <= '0;
            rd_gray_q    <= '0;
            inflight_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            rd_bin_q     <= rd_bin_d;
            rd_gray_q    <= rd_gray_d;
            inflight_q   <= fetch;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign rd_ptr_gray = rd_gray_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

endmodule
